// File: rtl/ql_mem_arbiter.sv
// Shared-SDRAM time-slot arbiter for the QL: 4-clock slots, 4-slot frame, video locked to slot 0.
// Issues one SDRAM command per slot and returns registered read data to the slot owner.
module ql_mem_arbiter #(
    parameter int AW     = 19,
    parameter int RD_LAT = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    output logic          video_cycle,
    input  logic          video_rd,
    input  logic [AW-1:0] video_addr,
    output logic [15:0]   video_din,
    input  logic          mdv_men,
    input  logic          mdv_req,
    input  logic          mdv_we,
    input  logic [AW-1:0] mdv_addr,
    input  logic [15:0]   mdv_wdata,
    output logic          mdv_ack,
    output logic [15:0]   mdv_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_ds,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [15:0]   cpu_rdata,
    output logic          sd_req,
    output logic          sd_we,
    output logic [1:0]    sd_be,
    output logic [AW-1:0] sd_addr,
    output logic [15:0]   sd_wdata,
    input  logic [15:0]   sd_rdata
);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_CPU   = 2'd2,
        OWN_MDV   = 2'd3
    } owner_e;

    // Outputs lag the counters by one clock, so data returned during output phase
    // RD_LAT is captured on the edge where phase_r has moved one step further.
    localparam logic [1:0] CAP_PHASE = 2'(RD_LAT + 1);

    logic [1:0] phase_r;
    logic [1:0] slot_r;
    logic [1:0] phase_nxt_s;
    logic [1:0] slot_nxt_s;
    owner_e     owner_r;
    owner_e     owner_nxt_s;
    owner_e     grant_s;
    logic       slot_start_s;

    assign slot_start_s = (phase_r == 2'd0);

    // Slot priority table: requests sampled at the slot boundary pick the owner.
    always_comb begin
        grant_s = OWN_IDLE;
        case (slot_r)
            2'd0: begin
                if (video_rd) begin
                    grant_s = OWN_VIDEO;
                end else if (mdv_men && mdv_req) begin
                    grant_s = OWN_MDV;
                end else begin
                    grant_s = OWN_IDLE;
                end
            end
            2'd2: begin
                if (mdv_req && mdv_men) begin
                    grant_s = OWN_MDV;
                end else if (cpu_req) begin
                    grant_s = OWN_CPU;
                end else if (mdv_req) begin
                    grant_s = OWN_MDV;
                end else begin
                    grant_s = OWN_IDLE;
                end
            end
            2'd1, 2'd3: begin
                if (cpu_req) begin
                    grant_s = OWN_CPU;
                end else if (mdv_req) begin
                    grant_s = OWN_MDV;
                end else begin
                    grant_s = OWN_IDLE;
                end
            end
            default: begin
                grant_s = OWN_IDLE;
            end
        endcase
    end

    // Next-state for phase/slot counters and the slot owner.
    always_comb begin
        phase_nxt_s = phase_r + 2'd1;
        slot_nxt_s  = slot_r;
        owner_nxt_s = owner_r;
        if (phase_r == 2'd3) begin
            slot_nxt_s = slot_r + 2'd1;
        end else begin
            slot_nxt_s = slot_r;
        end
        if (slot_start_s) begin
            owner_nxt_s = grant_s;
        end else begin
            owner_nxt_s = owner_r;
        end
    end

    // Counter and owner state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= 2'd0;
            slot_r  <= 2'd0;
            owner_r <= OWN_IDLE;
        end else begin
            phase_r <= phase_nxt_s;
            slot_r  <= slot_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    // SDRAM command, video strobe and ack registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            video_cycle <= 1'b0;
            sd_req      <= 1'b0;
            sd_we       <= 1'b0;
            sd_be       <= 2'b00;
            sd_addr     <= {AW{1'b0}};
            sd_wdata    <= 16'h0000;
            cpu_ack     <= 1'b0;
            mdv_ack     <= 1'b0;
        end else begin
            video_cycle <= (slot_r == 2'd0);
            sd_req      <= slot_start_s && (grant_s != OWN_IDLE);
            cpu_ack     <= (phase_r == 2'd3) && (owner_r == OWN_CPU);
            mdv_ack     <= (phase_r == 2'd3) && (owner_r == OWN_MDV);
            if (slot_start_s) begin
                case (grant_s)
                    OWN_VIDEO: begin
                        sd_we   <= 1'b0;
                        sd_be   <= 2'b11;
                        sd_addr <= video_addr;
                    end
                    OWN_CPU: begin
                        sd_we    <= cpu_we;
                        sd_be    <= cpu_ds;
                        sd_addr  <= cpu_addr;
                        sd_wdata <= cpu_wdata;
                    end
                    OWN_MDV: begin
                        sd_we    <= mdv_we;
                        sd_be    <= 2'b11;
                        sd_addr  <= mdv_addr;
                        sd_wdata <= mdv_wdata;
                    end
                    default: begin
                        sd_we <= 1'b0;
                        sd_be <= 2'b00;
                    end
                endcase
            end
        end
    end

    // Read data return into the owner's holding register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            video_din <= 16'h0000;
            cpu_rdata <= 16'h0000;
            mdv_rdata <= 16'h0000;
        end else if ((phase_r == CAP_PHASE) && !sd_we) begin
            case (owner_r)
                OWN_VIDEO: video_din <= sd_rdata;
                OWN_CPU:   cpu_rdata <= sd_rdata;
                OWN_MDV:   mdv_rdata <= sd_rdata;
                default:   begin end
            endcase
        end
    end

endmodule

// File: tb/tb_ql_mem_arbiter.sv
// Randomized bench for ql_mem_arbiter against a cycle-indexed slot/phase reference model.
module tb_ql_mem_arbiter;
    localparam int AW     = 19;
    localparam int RD_LAT = 2;

    logic          clk_sys;
    logic          reset_n;
    logic          video_cycle;
    logic          video_rd;
    logic [AW-1:0] video_addr;
    logic [15:0]   video_din;
    logic          mdv_men;
    logic          mdv_req;
    logic          mdv_we;
    logic [AW-1:0] mdv_addr;
    logic [15:0]   mdv_wdata;
    logic          mdv_ack;
    logic [15:0]   mdv_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_ds;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_wdata;
    logic          cpu_ack;
    logic [15:0]   cpu_rdata;
    logic          sd_req;
    logic          sd_we;
    logic [1:0]    sd_be;
    logic [AW-1:0] sd_addr;
    logic [15:0]   sd_wdata;
    logic [15:0]   sd_rdata;

    ql_mem_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .video_cycle(video_cycle),
        .video_rd(video_rd), .video_addr(video_addr), .video_din(video_din),
        .mdv_men(mdv_men), .mdv_req(mdv_req), .mdv_we(mdv_we), .mdv_addr(mdv_addr),
        .mdv_wdata(mdv_wdata), .mdv_ack(mdv_ack), .mdv_rdata(mdv_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ds(cpu_ds), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .sd_req(sd_req), .sd_we(sd_we), .sd_be(sd_be), .sd_addr(sd_addr),
        .sd_wdata(sd_wdata), .sd_rdata(sd_rdata)
    );

    initial begin
        clk_sys = 1'b0;
        forever #24 clk_sys = ~clk_sys;
    end

    int n_vec;
    int n_err;

    // Reference model state: k counts clocks since reset release.
    int          k;
    int          m_own;  // 0 idle, 1 video, 2 cpu, 3 mdv
    logic        m_we;
    logic [1:0]  m_be;
    logic [18:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_vid;
    logic [15:0] m_cpu;
    logic [15:0] m_mdv;
    bit          stim_en;
    int          cpu_load;
    int          mdv_load;
    int          vid_load;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t, clk %0d)", tag, got, exp, $time, k);
        end
    endtask

    task automatic model_reset();
        k       = 0;
        m_own   = 0;
        m_we    = 1'b0;
        m_be    = 2'b00;
        m_addr  = 19'h00000;
        m_wdata = 16'h0000;
        m_vid   = 16'h0000;
        m_cpu   = 16'h0000;
        m_mdv   = 16'h0000;
    endtask

    function automatic int pick_owner(input int sl);
        if (sl == 0) return video_rd ? 1 : ((mdv_req && mdv_men) ? 3 : 0);
        if (sl == 2 && mdv_req && mdv_men) return 3;
        if (cpu_req) return 2;
        return mdv_req ? 3 : 0;
    endfunction

    task automatic new_cpu();
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom);
        cpu_ds    = 2'($urandom_range(1, 3));
        cpu_addr  = 19'($urandom);
        cpu_wdata = 16'($urandom);
    endtask

    task automatic new_mdv();
        mdv_req   = 1'b1;
        mdv_we    = 1'($urandom);
        mdv_addr  = 19'($urandom);
        mdv_wdata = 16'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {26'h0, video_cycle, mdv_ack, cpu_ack, sd_req, sd_we, 1'b0}, 32'h0);
        chk({tag, "_be"}, sd_be, 32'h0);
        chk({tag, "_addr"}, sd_addr, 32'h0);
        chk({tag, "_wdata"}, sd_wdata, 32'h0);
        chk({tag, "_vdin"}, video_din, 32'h0);
        chk({tag, "_cpurd"}, cpu_rdata, 32'h0);
        chk({tag, "_mdvrd"}, mdv_rdata, 32'h0);
    endtask

    task automatic step_cycle();
        int ph;
        int sl;
        bit ack_c;
        bit ack_m;
        @(posedge clk_sys);
        #1;
        ph = k % 4;
        sl = (k / 4) % 4;
        if (ph == 0) begin
            m_own = pick_owner(sl);
            case (m_own)
                1: begin m_we = 1'b0; m_be = 2'b11; m_addr = video_addr; end
                2: begin m_we = cpu_we; m_be = cpu_ds; m_addr = cpu_addr; m_wdata = cpu_wdata; end
                3: begin m_we = mdv_we; m_be = 2'b11; m_addr = mdv_addr; m_wdata = mdv_wdata; end
                default: begin m_we = 1'b0; m_be = 2'b00; end
            endcase
        end
        ack_c = (ph == 3) && (m_own == 2);
        ack_m = (ph == 3) && (m_own == 3);
        chk("video_cycle", video_cycle, sl == 0);
        chk("sd_req", sd_req, (ph == 0) && (m_own != 0));
        chk("sd_we", sd_we, m_we);
        chk("sd_be", sd_be, m_be);
        chk("sd_addr", sd_addr, m_addr);
        chk("sd_wdata", sd_wdata, m_wdata);
        chk("cpu_ack", cpu_ack, ack_c);
        chk("mdv_ack", mdv_ack, ack_m);
        chk("video_din", video_din, m_vid);
        chk("cpu_rdata", cpu_rdata, m_cpu);
        chk("mdv_rdata", mdv_rdata, m_mdv);

        // SDRAM returns fresh data every clock; only the RD_LAT beat of a read counts.
        sd_rdata = 16'($urandom);
        if (ph == RD_LAT && m_own != 0 && !m_we) begin
            case (m_own)
                1: m_vid = sd_rdata;
                2: m_cpu = sd_rdata;
                default: m_mdv = sd_rdata;
            endcase
        end

        if (stim_en) begin
            if (cpu_req) begin
                if (ack_c) begin
                    if ($urandom_range(0, 1) == 1) new_cpu();
                    else cpu_req = 1'b0;
                end
            end else if ($urandom_range(0, 99) < cpu_load) begin
                new_cpu();
            end
            if (mdv_req) begin
                if (ack_m) begin
                    if ($urandom_range(0, 1) == 1) new_mdv();
                    else mdv_req = 1'b0;
                end
            end else if ($urandom_range(0, 99) < mdv_load) begin
                new_mdv();
            end
            video_rd   = ($urandom_range(0, 99) < vid_load);
            video_addr = 19'($urandom);
            if ($urandom_range(0, 15) == 0) mdv_men = ~mdv_men;
        end
        k++;
    endtask

    initial begin
        bit hit;
        n_vec    = 0;
        n_err    = 0;
        stim_en  = 1'b0;
        reset_n  = 1'b1;
        video_rd = 1'b1;
        video_addr = 19'h10000;
        mdv_men  = 1'b1;
        mdv_req  = 1'b0;
        mdv_we   = 1'b0;
        mdv_addr = 19'h00000;
        mdv_wdata = 16'h0000;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_ds   = 2'b11;
        cpu_addr = 19'h00000;
        cpu_wdata = 16'h0000;
        sd_rdata = 16'hA55A;
        model_reset();
        #5 reset_n = 1'b0;
        new_cpu();
        new_mdv();

        // Outputs must stay cleared while reset is held, even with requests pending.
        repeat (3) begin
            @(negedge clk_sys);
            check_all_zero("rst");
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();

        stim_en  = 1'b1;
        cpu_load = 30; mdv_load = 30; vid_load = 50;
        repeat (600) step_cycle();
        cpu_load = 90; mdv_load = 90; vid_load = 80;
        repeat (600) step_cycle();
        cpu_load = 10; mdv_load = 15; vid_load = 5;
        repeat (400) step_cycle();

        // Abort a CPU read mid-slot with an asynchronous reset, keeping the request held.
        stim_en   = 1'b0;
        video_rd  = 1'b0;
        mdv_req   = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_ds    = 2'b11;
        cpu_addr  = 19'h00456;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            step_cycle();
            if (((k - 1) % 4) == 1 && m_own == 2 && !m_we) hit = 1'b1;
        end
        chk("find_cpu_read_slot", hit, 1'b1);
        reset_n = 1'b0;
        #1;
        check_all_zero("arst");
        repeat (2) begin
            @(negedge clk_sys);
            check_all_zero("arst_hold");
        end
        reset_n = 1'b1;
        model_reset();
        repeat (16) step_cycle();
        chk("cpu_served_after_rst", m_cpu, cpu_rdata);

        stim_en  = 1'b1;
        cpu_load = 50; mdv_load = 50; vid_load = 50;
        repeat (300) step_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
